// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stage enables, bubbles, mem-wait timeout, halt/resume.
// Enables and bubbles are combinational from state and inputs; counters and status are registered.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int FLUSH_W     = 16
) (
  input  logic               in_CLK,
  input  logic               in_CLR,
  input  logic [4:0]         in_id_rs,
  input  logic [4:0]         in_id_rt,
  input  logic               in_id_rs_used,
  input  logic               in_id_rt_used,
  input  logic [4:0]         in_ex_rt,
  input  logic               in_ex_memread,
  input  logic               in_ex_branch,
  input  logic               in_mem_req,
  input  logic               in_mem_ack,
  input  logic               in_wb_halt,
  input  logic               in_go,
  output logic               out_en_pc,
  output logic               out_en_ifid,
  output logic               out_en_idex,
  output logic               out_en_exmem,
  output logic               out_en_memwb,
  output logic               out_bub_ifid,
  output logic               out_bub_idex,
  output logic               out_bub_memwb,
  output logic               out_halted,
  output logic               out_fault,
  output logic [31:0]        out_cycles,
  output logic [31:0]        out_stalls,
  output logic [FLUSH_W-1:0] out_flushes
);

  typedef enum logic [1:0] {ST_RUN, ST_MEMWAIT, ST_HALT} state_t;

  localparam logic [8:0] TO_LIM = 9'(MEM_TIMEOUT);

  state_t               state_q, state_d;
  logic [7:0]           tcnt_q, tcnt_d;
  logic                 halt_mask_q, halt_mask_d;
  logic                 go_q, go_d;
  logic                 fault_q, fault_d;
  logic [31:0]          cycles_q, cycles_d;
  logic [31:0]          stalls_q, stalls_d;
  logic [FLUSH_W-1:0]   flushes_q, flushes_d;

  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic bub_ifid, bub_idex, bub_memwb;
  logic load_use, mem_busy, flush, stall;

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    halt_mask_d = halt_mask_q;
    go_d        = in_go;
    fault_d     = fault_q;
    en_pc       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    bub_ifid    = 1'b0;
    bub_idex    = 1'b0;
    bub_memwb   = 1'b0;
    flush       = 1'b0;

    // A zero destination never creates a hazard.
    load_use = in_ex_memread && (in_ex_rt != 5'd0) &&
               ((in_id_rs_used && (in_id_rs == in_ex_rt)) ||
                (in_id_rt_used && (in_id_rt == in_ex_rt)));
    mem_busy = (state_q == ST_MEMWAIT) ? !in_mem_ack : (in_mem_req && !in_mem_ack);

    case (state_q)
      ST_HALT: begin
        en_pc    = 1'b0;
        en_ifid  = 1'b0;
        en_idex  = 1'b0;
        en_exmem = 1'b0;
        en_memwb = 1'b0;
        if (in_go && !go_q) begin
          state_d     = ST_RUN;
          halt_mask_d = 1'b1;
        end
      end
      default: begin
        halt_mask_d = 1'b0;
        if ((state_q == ST_RUN) && in_wb_halt && !halt_mask_q) begin
          en_pc    = 1'b0;
          en_ifid  = 1'b0;
          en_idex  = 1'b0;
          en_exmem = 1'b0;
          en_memwb = 1'b0;
          state_d  = ST_HALT;
        end else if (mem_busy) begin
          en_pc     = 1'b0;
          en_ifid   = 1'b0;
          en_idex   = 1'b0;
          en_exmem  = 1'b0;
          bub_memwb = 1'b1;
          if (state_q == ST_RUN) begin
            state_d = ST_MEMWAIT;
            tcnt_d  = 8'd1;
          end else if (({1'b0, tcnt_q} + 9'd1) >= TO_LIM) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
            tcnt_d  = 8'd0;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end else begin
          state_d = ST_RUN;
          tcnt_d  = 8'd0;
          // A taken branch flushes the dependent instruction, so it outranks load-use.
          if (in_ex_branch) begin
            bub_ifid = 1'b1;
            bub_idex = 1'b1;
            flush    = 1'b1;
          end else if (load_use) begin
            en_pc    = 1'b0;
            en_ifid  = 1'b0;
            bub_idex = 1'b1;
          end
        end
      end
    endcase

    stall = (state_q != ST_HALT) && !flush &&
            (!(en_pc && en_ifid && en_idex && en_exmem && en_memwb) ||
             bub_ifid || bub_idex || bub_memwb);

    cycles_d  = cycles_q + ((state_q != ST_HALT) ? 32'd1 : 32'd0);
    stalls_d  = stalls_q + (stall ? 32'd1 : 32'd0);
    flushes_d = flushes_q + (flush ? FLUSH_W'(1) : FLUSH_W'(0));
  end

  always_ff @(posedge in_CLK or posedge in_CLR) begin
    if (in_CLR) begin
      state_q     <= ST_RUN;
      tcnt_q      <= 8'd0;
      halt_mask_q <= 1'b0;
      go_q        <= 1'b1;
      fault_q     <= 1'b0;
      cycles_q    <= 32'd0;
      stalls_q    <= 32'd0;
      flushes_q   <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      halt_mask_q <= halt_mask_d;
      go_q        <= go_d;
      fault_q     <= fault_d;
      cycles_q    <= cycles_d;
      stalls_q    <= stalls_d;
      flushes_q   <= flushes_d;
    end
  end

  assign out_en_pc     = en_pc;
  assign out_en_ifid   = en_ifid;
  assign out_en_idex   = en_idex;
  assign out_en_exmem  = en_exmem;
  assign out_en_memwb  = en_memwb;
  assign out_bub_ifid  = bub_ifid;
  assign out_bub_idex  = bub_idex;
  assign out_bub_memwb = bub_memwb;
  assign out_halted    = (state_q == ST_HALT);
  assign out_fault     = fault_q;
  assign out_cycles    = cycles_q;
  assign out_stalls    = stalls_q;
  assign out_flushes   = flushes_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: decision table, hand-written multi-cycle corners, then random traffic vs a reference model.
module tb_pipeline_ctrl;

  localparam int TO = 4;
  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;

  typedef struct packed {
    logic [4:0] rs, rt, ex_rt;
    logic rs_used, rt_used, memread, branch, mem_req, mem_ack, wb_halt, go;
  } stim_t;

  typedef struct packed {
    stim_t      s;
    logic [7:0] ctl;
  } vec_t;

  logic in_CLK = 1'b0;
  logic in_CLR = 1'b1;
  logic [4:0] in_id_rs = '0, in_id_rt = '0, in_ex_rt = '0;
  logic in_id_rs_used = 0, in_id_rt_used = 0, in_ex_memread = 0, in_ex_branch = 0;
  logic in_mem_req = 0, in_mem_ack = 0, in_wb_halt = 0, in_go = 0;
  logic out_en_pc, out_en_ifid, out_en_idex, out_en_exmem, out_en_memwb;
  logic out_bub_ifid, out_bub_idex, out_bub_memwb, out_halted, out_fault;
  logic [31:0] out_cycles, out_stalls;
  logic [15:0] out_flushes;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .FLUSH_W(16)) dut (
    .in_CLK(in_CLK), .in_CLR(in_CLR),
    .in_id_rs(in_id_rs), .in_id_rt(in_id_rt),
    .in_id_rs_used(in_id_rs_used), .in_id_rt_used(in_id_rt_used),
    .in_ex_rt(in_ex_rt), .in_ex_memread(in_ex_memread), .in_ex_branch(in_ex_branch),
    .in_mem_req(in_mem_req), .in_mem_ack(in_mem_ack), .in_wb_halt(in_wb_halt), .in_go(in_go),
    .out_en_pc(out_en_pc), .out_en_ifid(out_en_ifid), .out_en_idex(out_en_idex),
    .out_en_exmem(out_en_exmem), .out_en_memwb(out_en_memwb),
    .out_bub_ifid(out_bub_ifid), .out_bub_idex(out_bub_idex), .out_bub_memwb(out_bub_memwb),
    .out_halted(out_halted), .out_fault(out_fault),
    .out_cycles(out_cycles), .out_stalls(out_stalls), .out_flushes(out_flushes)
  );

  always #5 in_CLK = ~in_CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_mode, m_wait;
  bit          m_mask, m_go, m_fault;
  logic [31:0] m_cycles, m_stalls;
  logic [15:0] m_flushes;

  function automatic stim_t mk(input int rs, rsu, rt, rtu, ext, mr, br, rq, ak, wh, g);
    stim_t s;
    s.rs = 5'(rs);   s.rs_used = 1'(rsu);
    s.rt = 5'(rt);   s.rt_used = 1'(rtu);
    s.ex_rt = 5'(ext); s.memread = 1'(mr);
    s.branch = 1'(br); s.mem_req = 1'(rq); s.mem_ack = 1'(ak);
    s.wb_halt = 1'(wh); s.go = 1'(g);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    in_id_rs = s.rs; in_id_rt = s.rt; in_ex_rt = s.ex_rt;
    in_id_rs_used = s.rs_used; in_id_rt_used = s.rt_used;
    in_ex_memread = s.memread; in_ex_branch = s.branch;
    in_mem_req = s.mem_req; in_mem_ack = s.mem_ack;
    in_wb_halt = s.wb_halt; in_go = s.go;
  endtask

  function automatic logic [7:0] ctl_now();
    return {out_en_pc, out_en_ifid, out_en_idex, out_en_exmem, out_en_memwb,
            out_bub_ifid, out_bub_idex, out_bub_memwb};
  endfunction

  // One clock: drive, check against the model, then advance the model at the edge.
  task automatic step(input stim_t s, output logic [7:0] got);
    logic [7:0] want;
    bit hz, busy, n_mask, n_fault;
    int n_mode, n_wait, st_inc, fl_inc;
    @(negedge in_CLK);
    apply(s);
    #1;
    got = ctl_now();
    hz = s.memread && s.ex_rt != 0 &&
         ((s.rs_used && s.rs == s.ex_rt) || (s.rt_used && s.rt == s.ex_rt));
    want = 8'b11111000;
    n_mode = m_mode; n_wait = m_wait; n_mask = m_mask; n_fault = m_fault;
    st_inc = 0; fl_inc = 0;
    if (m_mode == M_HALT) begin
      want = 8'h00;
      if (s.go && !m_go) begin n_mode = M_RUN; n_mask = 1; end
    end else begin
      n_mask = 0;
      busy = (m_mode == M_WAIT) ? !s.mem_ack : (s.mem_req && !s.mem_ack);
      if (m_mode == M_RUN && s.wb_halt && !m_mask) begin
        want = 8'h00; n_mode = M_HALT; st_inc = 1;
      end else if (busy) begin
        want = 8'b00001001; st_inc = 1;
        if (m_mode == M_RUN) begin n_mode = M_WAIT; n_wait = 1; end
        else if (m_wait + 1 >= TO) begin n_fault = 1; n_mode = M_HALT; n_wait = 0; end
        else n_wait = m_wait + 1;
      end else begin
        n_mode = M_RUN; n_wait = 0;
        if (s.branch) begin want = 8'b11111110; fl_inc = 1; end
        else if (hz) begin want = 8'b00111010; st_inc = 1; end
      end
    end
    chk("ctl", {24'd0, got}, {24'd0, want});
    chk("halted", {31'd0, out_halted}, {31'd0, m_mode == M_HALT});
    chk("fault", {31'd0, out_fault}, {31'd0, m_fault});
    chk("cycles", out_cycles, m_cycles);
    chk("stalls", out_stalls, m_stalls);
    chk("flushes", {16'd0, out_flushes}, {16'd0, m_flushes});
    @(posedge in_CLK);
    if (m_mode != M_HALT) m_cycles = m_cycles + 1;
    m_stalls  = m_stalls + 32'(st_inc);
    m_flushes = m_flushes + 16'(fl_inc);
    m_go = s.go; m_mode = n_mode; m_wait = n_wait; m_mask = n_mask; m_fault = n_fault;
  endtask

  // Async reset pulse asserted mid-cycle and held across one edge.
  task automatic do_reset();
    @(negedge in_CLK);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 in_CLR = 1'b1;
    #1;
    chk("rst_ctl", {24'd0, ctl_now()}, 32'h0000_00f8);
    chk("rst_halted", {31'd0, out_halted}, 32'd0);
    chk("rst_fault", {31'd0, out_fault}, 32'd0);
    chk("rst_cycles", out_cycles, 32'd0);
    chk("rst_stalls", out_stalls, 32'd0);
    chk("rst_flushes", {16'd0, out_flushes}, 32'd0);
    #5 in_CLR = 1'b0;
    m_mode = M_RUN; m_wait = 0; m_mask = 0; m_go = 1; m_fault = 0;
    m_cycles = 0; m_stalls = 0; m_flushes = 0;
  endtask

  initial begin
    vec_t tbl[10];
    stim_t s, idle, req, reqack, hzd;
    logic [7:0] got;
    logic [31:0] frozen;
    bit g;

    //                rs rsu rt rtu ext mr br rq ak wh go
    tbl[0] = '{mk(1, 1, 2, 1, 3, 0, 0, 0, 0, 0, 0), 8'b11111000};
    tbl[1] = '{mk(5, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0), 8'b00111010};
    tbl[2] = '{mk(1, 1, 7, 1, 7, 1, 0, 0, 0, 0, 0), 8'b00111010};
    tbl[3] = '{mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), 8'b11111000};
    tbl[4] = '{mk(5, 0, 2, 1, 5, 1, 0, 0, 0, 0, 0), 8'b11111000};
    tbl[5] = '{mk(5, 1, 5, 1, 5, 0, 0, 0, 0, 0, 0), 8'b11111000};
    tbl[6] = '{mk(5, 1, 2, 1, 5, 1, 1, 0, 0, 0, 0), 8'b11111110};
    tbl[7] = '{mk(3, 1, 4, 1, 6, 0, 1, 0, 0, 0, 0), 8'b11111110};
    tbl[8] = '{mk(9, 1, 2, 0, 9, 1, 0, 1, 1, 0, 0), 8'b00111010};
    tbl[9] = '{mk(1, 1, 8, 0, 8, 1, 0, 0, 0, 0, 0), 8'b11111000};

    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    req    = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    reqack = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    hzd    = mk(5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);

    do_reset();

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s, got);
      chk($sformatf("tbl%0d", i), {24'd0, got}, {24'd0, tbl[i].ctl});
    end

    // Load-use: exactly one stall cycle.
    do_reset();
    step(hzd, got);
    step(idle, got);
    chk("lu_next_ctl", {24'd0, got}, 32'h0000_00f8);
    #1 chk("lu_stalls", out_stalls, 32'd1);

    // Branch together with a load-use hazard counts as a flush only.
    do_reset();
    step(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0), got);
    #1 chk("br_flushes", {16'd0, out_flushes}, 32'd1);
    chk("br_stalls", out_stalls, 32'd0);

    // Memory ack after three wait cycles releases on the ack cycle.
    do_reset();
    step(req, got); step(req, got); step(req, got);
    chk("mw_ctl", {24'd0, got}, 32'h0000_0009);
    step(reqack, got);
    chk("ack_ctl", {24'd0, got}, 32'h0000_00f8);
    #1 chk("ack_stalls", out_stalls, 32'd3);
    chk("ack_fault", {31'd0, out_fault}, 32'd0);

    // Timeout after TO consecutive wait cycles.
    do_reset();
    for (int i = 0; i < TO; i++) step(req, got);
    #1 chk("to_fault", {31'd0, out_fault}, 32'd1);
    chk("to_halted", {31'd0, out_halted}, 32'd1);
    step(idle, got);
    chk("to_ctl", {24'd0, got}, 32'd0);

    // Reset in the middle of a memory wait.
    do_reset();
    step(req, got); step(req, got);
    do_reset();

    // Halt, go held high across entry, then a fresh go edge resumes with halt masked.
    do_reset();
    step(idle, got);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), got);
    chk("h_entry_ctl", {24'd0, got}, 32'd0);
    #1 frozen = out_cycles;
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), got);
    #1 chk("h_held_halted", {31'd0, out_halted}, 32'd1);
    chk("h_cycles_frozen", out_cycles, frozen);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), got);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), got);
    #1 chk("h_resume", {31'd0, out_halted}, 32'd0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), got);
    chk("h_masked_ctl", {24'd0, got}, 32'h0000_00f8);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), got);
    chk("h_rehalt_ctl", {24'd0, got}, 32'd0);

    // Random traffic.
    do_reset();
    g = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 599) do_reset();
      if ($urandom_range(0, 3) == 0) g = !g;
      s = mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
             $urandom_range(0, 1), ($urandom_range(0, 15) == 0), g);
      step(s, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
